siso_frame_arb: RTL and testbench
=================================

Name: siso_frame_arb

Overview:
- Round-robin, frame-granular arbiter that lets NUM_SRC byte-stream requesters share one single-clock FIFO (DATA_WIDTH+1 wide: byte plus last flag) on the Ethernet TX path.
- Grants one source and holds the grant until that source's frame ends, so frames never interleave in the FIFO.
- Enforces a maximum frame length: an over-long frame is truncated, and the source's remaining bytes are discarded.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_WIDTH, 8, payload width per beat.
- MAX_LEN, 1518, maximum beats per frame before truncation.
- LEN_WIDTH, $clog2(MAX_LEN+1), frame beat counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- src_valid  in  NUM_SRC  per-source beat valid.
- src_data  in  NUM_SRC*DATA_WIDTH  per-source beat; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_last  in  NUM_SRC  per-source last-beat-of-frame flag.
- src_ready  out  NUM_SRC  per-source beat accepted (combinational).
- fifo_wr_en  out  1  FIFO write strobe (combinational).
- fifo_din  out  DATA_WIDTH+1  {last, data} to FIFO.
- fifo_full  in  1  FIFO full.
- grant  out  NUM_SRC  one-hot current owner; all zero in IDLE.
- busy  out  1  high in XFER or DROP.
- frame_len  out  LEN_WIDTH  beats written in the current frame.
- err_trunc  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, last-granted pointer=NUM_SRC-1, frame_len=0, err_trunc=0. src_ready=0 and fifo_wr_en=0 while in reset.
- States: IDLE, XFER, DROP.
- IDLE:
  - Scan src_valid starting at (last_ptr+1) mod NUM_SRC and wrap around; the first set bit wins.
  - Register the winner into grant and last_ptr, clear frame_len, go to XFER.
  - Arbitration latency is 1 cycle; no beat is transferred in IDLE. With no valid source, stay in IDLE.
- XFER, owner g:
  - src_ready[g] = ~fifo_full; all other src_ready bits = 0.
  - fifo_wr_en = src_valid[g] & ~fifo_full.
  - fifo_din = {src_last[g] | force_last, src_data[g]}.
  - Each write increments frame_len.
  - src_valid[g] may drop mid-frame: the grant is held indefinitely and there is no timeout.
- End of frame:
  - A write with src_last[g]=1 moves to IDLE next cycle.
  - A source cannot win twice in a row while another source is valid (fairness).
- Truncation:
  - force_last=1 when frame_len==MAX_LEN-1 and src_last[g]=0.
  - That write carries last=1, err_trunc pulses in the same cycle as the write, and the state goes to DROP.
- DROP:
  - src_ready[g]=1 unconditionally; fifo_wr_en=0.
  - Beats are discarded until an accepted beat with src_last[g]=1, then go to IDLE.
  - frame_len is held.
- A frame of exactly MAX_LEN beats whose last beat has src_last=1 is not truncated.
- fifo_full held high stalls the transfer with no beat loss and no state change.
- fifo_din is don't-care whenever fifo_wr_en=0.
- A source withdrawing src_valid in the same cycle it is granted has no effect; the grant stands.
- Reset mid-frame aborts immediately. The FIFO may keep a partial frame; flushing it is the system reset's job.
- frame_len saturates at MAX_LEN.

Decomposition:
- Shared package: state encoding (IDLE/XFER/DROP) and the FIFO word layout constants (LAST_BIT=DATA_WIDTH).
- One natural sub-module: rr_pick, a combinational round-robin priority picker (req, last_ptr -> one-hot grant, index, any).

Test Plan:
- Single source 0 sends a 3-beat frame 0xA1,0xA2,0xA3(last), FIFO never full -> grant=0001 one cycle after valid; FIFO receives 0x0A1,0x0A2,0x1A3; state returns to IDLE.
- Sources 0..3 all valid with 2-beat frames -> grants in order 0,1,2,3 and then 0 again; FIFO frames are contiguous with no interleave.
- fifo_full asserted for 5 cycles mid-frame -> src_ready=0 and fifo_wr_en=0 throughout; no beat dropped or duplicated; frame_len unchanged during the stall.
- MAX_LEN=4, source sends a 7-beat frame -> 4 writes, the 4th with last=1; one err_trunc pulse; beats 5..7 accepted and dropped; then IDLE.
- MAX_LEN=4, source sends exactly 4 beats with last on the 4th -> no err_trunc; normal return to IDLE.
- rst_n pulsed low during XFER -> grant=0, busy=0, outputs quiet immediately; the next arbitration after release starts at source 0.

Source files
------------

// File: rtl/siso_frame_arb_pkg.sv
// rtl/siso_frame_arb_pkg.sv - shared state encoding and FIFO word layout for the frame arbiter
package siso_frame_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DROP = 2'd2
   } arb_state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int LAST_BIT       = DEF_DATA_WIDTH;

   // FIFO word is {last, data}; the last flag sits just above the payload.
   function automatic int last_bit(input int data_width);
      return data_width;
   endfunction

endpackage

// File: rtl/siso_frame_arb_if.sv
// rtl/siso_frame_arb_if.sv - source/FIFO/status bundle between requesters and the frame arbiter
interface siso_frame_arb_if
   import siso_frame_arb_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 11
);
   logic [NUM_SRC-1:0]            src_valid;
   logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]            src_last;
   logic [NUM_SRC-1:0]            src_ready;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH:0]           fifo_din;
   logic                          fifo_full;
   logic [NUM_SRC-1:0]            grant;
   logic                          busy;
   logic [LEN_WIDTH-1:0]          frame_len;
   logic                          err_trunc;

   modport master (
      output src_valid, src_data, src_last, fifo_full,
      input  src_ready, fifo_wr_en, fifo_din, grant, busy, frame_len, err_trunc
   );

   modport slave (
      input  src_valid, src_data, src_last, fifo_full,
      output src_ready, fifo_wr_en, fifo_din, grant, busy, frame_len, err_trunc
   );
endinterface

// File: rtl/siso_frame_arb_rr_pick.sv
// rtl/siso_frame_arb_rr_pick.sv - combinational round-robin picker starting one past last_ptr
module siso_frame_arb_rr_pick
   import siso_frame_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDXW = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [IDXW-1:0] last_ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IDXW-1:0] idx_o,
   output logic            any_o
);

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      // k runs 1..N so the previous winner is considered last.
      for (int k = 1; k <= N; k++) begin
         if (!any_o && req_i[(int'(last_ptr_i) + k) % N]) begin
            any_o = 1'b1;
            idx_o = IDXW'((int'(last_ptr_i) + k) % N);
            gnt_o[(int'(last_ptr_i) + k) % N] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/siso_frame_arb.sv
// rtl/siso_frame_arb.sv - frame-granular round-robin arbiter feeding one TX FIFO with length truncation
module siso_frame_arb
   import siso_frame_arb_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 1518,
   parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
   input logic             clk,
   input logic             rst_n,
   siso_frame_arb_if.slave bus
);

   localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int LB   = last_bit(DATA_WIDTH);

   arb_state_e           state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [IDXW-1:0]      last_ptr_q, last_ptr_d;
   logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;

   logic [NUM_SRC-1:0]    pick_gnt;
   logic [IDXW-1:0]       pick_idx;
   logic                  pick_any;
   logic                  own_valid, own_last, force_last;
   logic [DATA_WIDTH-1:0] own_data;
   logic [NUM_SRC-1:0]    src_ready;
   logic                  fifo_wr_en;
   logic [DATA_WIDTH:0]   fifo_din;
   logic                  err_trunc;

   siso_frame_arb_rr_pick #(
      .N    (NUM_SRC),
      .IDXW (IDXW)
   ) u_pick (
      .req_i      (bus.src_valid),
      .last_ptr_i (last_ptr_q),
      .gnt_o      (pick_gnt),
      .idx_o      (pick_idx),
      .any_o      (pick_any)
   );

   // The owner's index is always the last-granted pointer while a frame is open.
   assign own_valid  = bus.src_valid[last_ptr_q];
   assign own_last   = bus.src_last[last_ptr_q];
   assign own_data   = bus.src_data[last_ptr_q*DATA_WIDTH +: DATA_WIDTH];
   assign force_last = (frame_len_q == LEN_WIDTH'(MAX_LEN - 1)) && !own_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         last_ptr_q  <= IDXW'(NUM_SRC - 1);
         frame_len_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_ptr_q  <= last_ptr_d;
         frame_len_q <= frame_len_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_ptr_d  = last_ptr_q;
      frame_len_d = frame_len_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d     = pick_gnt;
               last_ptr_d  = pick_idx;
               frame_len_d = '0;
               state_d     = ST_XFER;
            end
         end
         ST_XFER: begin
            if (fifo_wr_en) begin
               frame_len_d = (frame_len_q == LEN_WIDTH'(MAX_LEN)) ? frame_len_q
                                                                 : frame_len_q + 1'b1;
               if (own_last) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
               end else if (force_last) begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (own_valid && own_last) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      src_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      err_trunc  = 1'b0;
      case (state_q)
         ST_XFER: begin
            src_ready[last_ptr_q]  = ~bus.fifo_full;
            fifo_wr_en             = own_valid & ~bus.fifo_full;
            fifo_din[LB]           = own_last | force_last;
            fifo_din[LB-1:0]       = own_data;
            err_trunc              = fifo_wr_en & force_last;
         end
         ST_DROP: begin
            src_ready[last_ptr_q] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.src_ready  = src_ready;
   assign bus.fifo_wr_en = fifo_wr_en;
   assign bus.fifo_din   = fifo_din;
   assign bus.err_trunc  = err_trunc;
   assign bus.grant      = grant_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.frame_len  = frame_len_q;

endmodule

// File: tb/tb_siso_frame_arb.sv
// tb/tb_siso_frame_arb.sv - directed bench with a per-cycle reference model of the frame arbiter
module tb_siso_frame_arb;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int MAXL = 4;
   localparam int LW   = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   siso_frame_arb_if #(.NUM_SRC(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   siso_frame_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_LEN(MAXL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0]   src_q[N][$];
   logic [N-1:0] acc = '0;
   logic [8:0]   dut_log[$], mdl_log[$], exp_q[$];
   logic [N-1:0] gnt_log[$], exp_g[$];
   logic [N-1:0] prev_grant = '0;
   int           trunc_cnt = 0;

   // Reference model: owner index (-1 when idle), round-robin pointer, beats written, drop flag.
   int owner = -1, ptr = N - 1, cnt = 0, nxt;
   bit drop = 1'b0;
   logic [N-1:0] e_ready, e_grant;
   logic         e_wr, e_tr;
   logic [8:0]   e_din;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      e_ready = '0;
      e_wr    = 1'b0;
      e_tr    = 1'b0;
      e_din   = '0;
      if (!rst_n) begin
         owner = -1;
         ptr   = N - 1;
         cnt   = 0;
         drop  = 1'b0;
      end
      e_grant = (owner >= 0) ? N'(1 << owner) : '0;
      if (rst_n && owner >= 0) begin
         if (!drop) begin
            e_ready[owner] = !bus.fifo_full;
            if (bus.src_valid[owner] && !bus.fifo_full) begin
               e_wr  = 1'b1;
               e_tr  = (cnt == MAXL - 1) && !bus.src_last[owner];
               e_din = {bus.src_last[owner] | e_tr, bus.src_data[owner*DW +: DW]};
            end
         end else begin
            e_ready[owner] = 1'b1;
         end
      end

      chk("grant",      32'(bus.grant),      32'(e_grant));
      chk("busy",       32'(bus.busy),       32'(owner >= 0));
      chk("frame_len",  32'(bus.frame_len),  32'(cnt));
      chk("src_ready",  32'(bus.src_ready),  32'(e_ready));
      chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
      chk("err_trunc",  32'(bus.err_trunc),  32'(e_tr));
      if (e_wr) chk("fifo_din", 32'(bus.fifo_din), 32'(e_din));

      if (bus.fifo_wr_en === 1'b1) dut_log.push_back(bus.fifo_din);
      if (e_wr) mdl_log.push_back(e_din);
      if (bus.err_trunc === 1'b1) trunc_cnt++;
      if (bus.grant != '0 && prev_grant == '0) gnt_log.push_back(bus.grant);
      prev_grant = bus.grant;
      acc = bus.src_valid & bus.src_ready;

      if (rst_n) begin
         if (owner < 0) begin
            nxt = -1;
            for (int k = 1; k <= N; k++)
               if (nxt < 0 && bus.src_valid[(ptr + k) % N]) nxt = (ptr + k) % N;
            if (nxt >= 0) begin
               owner = nxt;
               ptr   = nxt;
               cnt   = 0;
            end
         end else if (!drop) begin
            if (e_wr) begin
               cnt = (cnt < MAXL) ? cnt + 1 : MAXL;
               if (bus.src_last[owner]) owner = -1;
               else if (e_tr) drop = 1'b1;
            end
         end else if (bus.src_valid[owner] && bus.src_last[owner]) begin
            owner = -1;
            drop  = 1'b0;
         end
      end
   end

   // Source BFMs: present queue heads, retire beats accepted on the previous edge.
   initial begin
      bus.src_valid = '0;
      bus.src_data  = '0;
      bus.src_last  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               bus.src_valid[i]          = 1'b1;
               bus.src_data[i*DW +: DW]  = src_q[i][0][7:0];
               bus.src_last[i]           = src_q[i][0][8];
            end else begin
               bus.src_valid[i] = 1'b0;
               bus.src_last[i]  = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic sb(input int s, input logic [8:0] b);
      src_q[s].push_back(b);
   endtask

   task automatic eb(input logic [8:0] b);
      exp_q.push_back(b);
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_idle(input string name);
      int t = 0;
      while ((bus.busy || bus.src_valid != '0 || pending()) && t < 200) begin
         step();
         t++;
      end
      if (t >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: idle timeout, busy=%0b", name, bus.busy);
      end
      step();
      step();
   endtask

   task automatic wait_len(input string name, input int len);
      int t = 0;
      while (bus.frame_len != LW'(len) && t < 100) begin
         step();
         t++;
      end
      if (t >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: frame_len never reached %0d, got %0d", name, len, bus.frame_len);
      end
   endtask

   task automatic clear_logs();
      dut_log.delete();
      mdl_log.delete();
      exp_q.delete();
      gnt_log.delete();
      exp_g.delete();
      trunc_cnt = 0;
   endtask

   task automatic chk_logs(input string name);
      chk({name, "_dut_len"}, 32'(dut_log.size()), 32'(exp_q.size()));
      chk({name, "_mdl_len"}, 32'(mdl_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < dut_log.size()) chk({name, "_dut_beat"}, 32'(dut_log[i]), 32'(exp_q[i]));
         if (i < mdl_log.size()) chk({name, "_mdl_beat"}, 32'(mdl_log[i]), 32'(exp_q[i]));
      end
      chk({name, "_ngrants"}, 32'(gnt_log.size()), 32'(exp_g.size()));
      for (int i = 0; i < exp_g.size(); i++)
         if (i < gnt_log.size()) chk({name, "_grant_seq"}, 32'(gnt_log[i]), 32'(exp_g[i]));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.fifo_full = 1'b0;
      repeat (3) step();
      chk("reset_grant", 32'(bus.grant), 32'h0);
      chk("reset_len",   32'(bus.frame_len), 32'h0);
      rst_n = 1'b1;
      step();

      // Single 3-beat frame from source 0.
      clear_logs();
      sb(0, 9'h0A1); sb(0, 9'h0A2); sb(0, 9'h1A3);
      eb(9'h0A1); eb(9'h0A2); eb(9'h1A3);
      exp_g.push_back(4'b0001);
      wait_idle("s1");
      chk_logs("s1");

      // All four sources contend; source 0 has a second frame queued.
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      clear_logs();
      for (int i = 0; i < N; i++) begin
         sb(i, {1'b0, 8'(i * 16)});
         sb(i, {1'b1, 8'(i * 16 + 1)});
         eb({1'b0, 8'(i * 16)});
         eb({1'b1, 8'(i * 16 + 1)});
      end
      sb(0, 9'h005); sb(0, 9'h106);
      eb(9'h005); eb(9'h106);
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
      exp_g.push_back(4'b0100); exp_g.push_back(4'b1000);
      exp_g.push_back(4'b0001);
      wait_idle("s2");
      chk_logs("s2");

      // FIFO full for 5 cycles after the first beat.
      clear_logs();
      sb(1, 9'h0C1); sb(1, 9'h0C2); sb(1, 9'h1C3);
      eb(9'h0C1); eb(9'h0C2); eb(9'h1C3);
      exp_g.push_back(4'b0010);
      wait_len("s3", 1);
      bus.fifo_full = 1'b1;
      repeat (5) begin
         #1;
         chk("stall_wr_en", 32'(bus.fifo_wr_en), 32'h0);
         chk("stall_ready", 32'(bus.src_ready), 32'h0);
         chk("stall_len",   32'(bus.frame_len), 32'h1);
         step();
      end
      bus.fifo_full = 1'b0;
      wait_idle("s3");
      chk_logs("s3");

      // 7-beat frame truncated at MAX_LEN=4.
      clear_logs();
      sb(2, 9'h0D1); sb(2, 9'h0D2); sb(2, 9'h0D3); sb(2, 9'h0D4);
      sb(2, 9'h0D5); sb(2, 9'h0D6); sb(2, 9'h1D7);
      eb(9'h0D1); eb(9'h0D2); eb(9'h0D3); eb(9'h1D4);
      exp_g.push_back(4'b0100);
      wait_idle("s4");
      chk_logs("s4");
      chk("s4_trunc_pulses", 32'(trunc_cnt), 32'd1);
      chk("s4_all_consumed", 32'(src_q[2].size()), 32'd0);
      chk("s4_len_held",     32'(bus.frame_len), 32'd4);

      // Exactly MAX_LEN beats with last on the final one.
      clear_logs();
      sb(3, 9'h0E1); sb(3, 9'h0E2); sb(3, 9'h0E3); sb(3, 9'h1E4);
      eb(9'h0E1); eb(9'h0E2); eb(9'h0E3); eb(9'h1E4);
      exp_g.push_back(4'b1000);
      wait_idle("s5");
      chk_logs("s5");
      chk("s5_trunc_pulses", 32'(trunc_cnt), 32'd0);

      // Reset mid-frame, then arbitration restarts at source 0.
      clear_logs();
      sb(1, 9'h0F1); sb(1, 9'h0F2); sb(1, 9'h0F3); sb(1, 9'h1F4);
      wait_len("s6", 2);
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      #1;
      chk("rst_grant",  32'(bus.grant),      32'h0);
      chk("rst_busy",   32'(bus.busy),       32'h0);
      chk("rst_ready",  32'(bus.src_ready),  32'h0);
      chk("rst_wr_en",  32'(bus.fifo_wr_en), 32'h0);
      step(); step();
      rst_n = 1'b1;
      step();
      clear_logs();
      sb(2, 9'h021); sb(2, 9'h122);
      sb(0, 9'h001); sb(0, 9'h102);
      eb(9'h001); eb(9'h102); eb(9'h021); eb(9'h122);
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0100);
      wait_idle("s6");
      chk_logs("s6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
